apb_lite_master18: RTL and testbench

APB Rev 2 initiator that turns a simple valid/ready request stream into two-phase APB transfers toward up to NSLV peripherals, such as the GPIO lite slave. It sits between an on-chip controller (CPU shim or test sequencer) and the peripheral APB fabric. It buffers requests in a small FIFO, decodes the target peripheral select from the upper address bits, and returns read data on a one-cycle response pulse. There is no pready: every transfer takes exactly one setup cycle plus one enable cycle.

---
 rtl/apb_lite_master18.sv | 195 +++++++++++++++++++
 tb/tb_apb_lite_master18.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_lite_master18.sv
// APB Rev 2 initiator: buffers valid/ready requests in a small FIFO and issues
// two-phase (SETUP/ENABLE) transfers with one-hot peripheral select.
module apb_lite_master18 #(
  parameter int ADDR_W     = 8,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      pclk18,
  input  logic                      p_reset18,
  input  logic                      req_valid18,
  output logic                      req_ready18,
  input  logic                      req_write18,
  input  logic [ADDR_W-1:0]         req_addr18,
  input  logic [31:0]               req_wdata18,
  output logic [(2**SEL_W)-1:0]     psel18,
  output logic                      penable18,
  output logic                      pwrite18,
  output logic [ADDR_W-1:0]         paddr18,
  output logic [31:0]               pwdata18,
  input  logic [(2**SEL_W)*32-1:0]  prdata_bus18,
  output logic                      rsp_valid18,
  output logic                      rsp_write18,
  output logic [31:0]               rsp_rdata18,
  output logic                      busy18
);

  localparam int NSLV  = 2**SEL_W;
  localparam int EW    = 1 + ADDR_W + 32;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ENABLE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic [NSLV-1:0]      psel_q, psel_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_write_q, rsp_write_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;

  logic                 push_s, go_setup_s, mem_push_s, mem_pop_s;
  logic [EW-1:0]        head_s;
  logic [31:0]          rd_slice_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign rd_slice_s = prdata_bus18[{sel_q, 5'd0} +: 32];

  // Next-state, FIFO bookkeeping and APB/response output computation
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    psel_d      = psel_q;
    sel_d       = sel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    push_s      = req_valid18 && ready_q;
    // An empty FIFO forwards the request being accepted straight into SETUP.
    head_s      = (count_q != CNT_W'(0)) ? mem_q[rd_ptr_q]
                                         : {req_write18, req_addr18, req_wdata18};

    case (state_q)
      IDLE:    go_setup_s = (count_q != CNT_W'(0)) || push_s;
      ENABLE:  go_setup_s = (count_q != CNT_W'(0)) || push_s;
      default: go_setup_s = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        state_d = go_setup_s ? SETUP : IDLE;
      end
      SETUP: begin
        state_d   = ENABLE;
        penable_d = 1'b1;
      end
      ENABLE: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = pwrite_q;
        rsp_rdata_d = pwrite_q ? 32'h0000_0000 : rd_slice_s;
        state_d     = go_setup_s ? SETUP : IDLE;
        psel_d      = {NSLV{1'b0}};
        penable_d   = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = {NSLV{1'b0}};
        penable_d = 1'b0;
      end
    endcase

    if (go_setup_s) begin
      pwrite_d  = head_s[EW-1];
      paddr_d   = head_s[32 +: ADDR_W];
      pwdata_d  = head_s[EW-1] ? head_s[31:0] : 32'h0000_0000;
      sel_d     = head_s[32 + ADDR_W - 1 -: SEL_W];
      penable_d = 1'b0;
      for (int k = 0; k < NSLV; k++) begin
        psel_d[k] = (head_s[32 + ADDR_W - 1 -: SEL_W] == SEL_W'(k));
      end
    end else begin
      sel_d = sel_q;
    end

    mem_pop_s  = go_setup_s && (count_q != CNT_W'(0));
    mem_push_s = push_s && !(go_setup_s && (count_q == CNT_W'(0)));

    if (mem_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (mem_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    count_d = count_q + CNT_W'(mem_push_s) - CNT_W'(mem_pop_s);
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d  = (count_d != CNT_W'(0)) || (state_d != IDLE);
  end

  // State, FIFO and output registers with synchronous reset
  always_ff @(posedge pclk18) begin
    if (p_reset18) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      psel_q      <= '0;
      sel_q       <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      psel_q      <= psel_d;
      sel_q       <= sel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (mem_push_s) begin
        mem_q[wr_ptr_q] <= {req_write18, req_addr18, req_wdata18};
      end
    end
  end

  assign req_ready18 = ready_q;
  assign busy18      = busy_q;
  assign psel18      = psel_q;
  assign penable18   = penable_q;
  assign pwrite18    = pwrite_q;
  assign paddr18     = paddr_q;
  assign pwdata18    = pwdata_q;
  assign rsp_valid18 = rsp_valid_q;
  assign rsp_write18 = rsp_write_q;
  assign rsp_rdata18 = rsp_rdata_q;

endmodule

// File: tb/tb_apb_lite_master18.sv
// Directed self-checking bench for apb_lite_master18 (ADDR_W=8, SEL_W=2, FIFO_DEPTH=2).
module tb_apb_lite_master18;

  logic         pclk18 = 1'b0;
  logic         p_reset18 = 1'b1;
  logic         req_valid18 = 1'b0;
  logic         req_ready18;
  logic         req_write18 = 1'b0;
  logic [7:0]   req_addr18 = 8'h00;
  logic [31:0]  req_wdata18 = 32'h0;
  logic [3:0]   psel18;
  logic         penable18;
  logic         pwrite18;
  logic [7:0]   paddr18;
  logic [31:0]  pwdata18;
  logic [127:0] prdata_bus18 = 128'h0;
  logic         rsp_valid18;
  logic         rsp_write18;
  logic [31:0]  rsp_rdata18;
  logic         busy18;

  int checks = 0;
  int errors = 0;

  apb_lite_master18 #(.ADDR_W(8), .SEL_W(2), .FIFO_DEPTH(2)) dut (
    .pclk18(pclk18), .p_reset18(p_reset18),
    .req_valid18(req_valid18), .req_ready18(req_ready18),
    .req_write18(req_write18), .req_addr18(req_addr18), .req_wdata18(req_wdata18),
    .psel18(psel18), .penable18(penable18), .pwrite18(pwrite18),
    .paddr18(paddr18), .pwdata18(pwdata18), .prdata_bus18(prdata_bus18),
    .rsp_valid18(rsp_valid18), .rsp_write18(rsp_write18), .rsp_rdata18(rsp_rdata18),
    .busy18(busy18)
  );

  always #5 pclk18 = ~pclk18;

  task automatic tick();
    @(posedge pclk18);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    req_valid18 = v;
    req_write18 = w;
    req_addr18  = a;
    req_wdata18 = d;
  endtask

  logic        b_w [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0]  b_a [5] = '{8'h00, 8'h44, 8'h80, 8'hC0, 8'h40};
  logic [31:0] b_d [5] = '{32'h0, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0};
  logic [31:0] b_r [5] = '{32'h0A0A_0A0A, 32'h0, 32'h2222_2222, 32'h3333_3333, 32'h1111_1111};

  initial begin
    int idx, ridx, psel_cnt, first_e, last_e;
    logic acc;

    // Reset state
    tick(); tick();
    chk("rst_psel", psel18, 32'h0);
    chk("rst_penable", penable18, 32'h0);
    chk("rst_ready", req_ready18, 32'h1);
    chk("rst_busy", busy18, 32'h0);
    chk("rst_rsp_valid", rsp_valid18, 32'h0);
    chk("rst_paddr", paddr18, 32'h0);
    chk("rst_rdata", rsp_rdata18, 32'h0);
    p_reset18 = 1'b0;
    tick();

    // Single write to slave 0
    drive(1'b1, 1'b1, 8'h04, 32'h0000_A5A5);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    chk("wr_setup_psel", psel18, 32'h1);
    chk("wr_setup_penable", penable18, 32'h0);
    chk("wr_setup_pwdata", pwdata18, 32'h0000_A5A5);
    chk("wr_setup_pwrite", pwrite18, 32'h1);
    chk("wr_setup_busy", busy18, 32'h1);
    tick();
    chk("wr_enable_psel", psel18, 32'h1);
    chk("wr_enable_penable", penable18, 32'h1);
    tick();
    chk("wr_rsp_valid", rsp_valid18, 32'h1);
    chk("wr_rsp_write", rsp_write18, 32'h1);
    chk("wr_rsp_rdata", rsp_rdata18, 32'h0);
    chk("wr_rsp_psel", psel18, 32'h0);
    chk("wr_rsp_busy", busy18, 32'h0);
    tick();
    chk("wr_rsp_once", rsp_valid18, 32'h0);

    // Read decode to slave 3
    prdata_bus18 = {32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    drive(1'b1, 1'b0, 8'hC8, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    chk("rd_psel", psel18, 32'h8);
    chk("rd_pwdata", pwdata18, 32'h0);
    chk("rd_paddr", paddr18, 32'hC8);
    tick();
    chk("rd_penable", penable18, 32'h1);
    tick();
    chk("rd_rsp_valid", rsp_valid18, 32'h1);
    chk("rd_rsp_write", rsp_write18, 32'h0);
    chk("rd_rsp_rdata", rsp_rdata18, 32'h0000_1234);
    tick();
    chk("rd_rdata_hold", rsp_rdata18, 32'h0000_1234);

    // Burst of 5 with backpressure
    prdata_bus18 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0A0A_0A0A};
    idx = 0; ridx = 0; psel_cnt = 0; first_e = -1; last_e = -1;
    for (int e = 1; e <= 14; e++) begin
      if (idx < 5) drive(1'b1, b_w[idx], b_a[idx], b_d[idx]);
      else drive(1'b0, 1'b0, 8'h00, 32'h0);
      acc = req_valid18 && req_ready18;
      tick();
      if (acc) idx++;
      if (e == 4) chk("burst_ready_low", req_ready18, 32'h0);
      if (e == 5) chk("burst_ready_back", req_ready18, 32'h1);
      if (e <= 10) chk("burst_penable", penable18, (e % 2 == 0) ? 32'h1 : 32'h0);
      if (psel18 != 4'h0) begin
        psel_cnt++;
        if (first_e < 0) first_e = e;
        last_e = e;
      end
      if (rsp_valid18) begin
        if (ridx < 5) begin
          chk("burst_rsp_write", rsp_write18, b_w[ridx]);
          chk("burst_rsp_rdata", rsp_rdata18, b_r[ridx]);
        end else begin
          chk("burst_extra_rsp", 32'(ridx), 32'd5);
        end
        ridx++;
      end
    end
    chk("burst_accepted", idx, 32'd5);
    chk("burst_rsp_count", ridx, 32'd5);
    chk("burst_psel_cycles", psel_cnt, 32'd10);
    chk("burst_no_gap", last_e - first_e + 1, 32'd10);
    chk("burst_busy_end", busy18, 32'h0);

    // Reset during ENABLE of a read
    drive(1'b1, 1'b0, 8'h40, 32'h0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rstmid_in_enable", penable18, 32'h1);
    p_reset18 = 1'b1;
    drive(1'b1, 1'b1, 8'h80, 32'h1234_5678);
    tick();
    chk("rstmid_psel", psel18, 32'h0);
    chk("rstmid_penable", penable18, 32'h0);
    chk("rstmid_ready", req_ready18, 32'h1);
    chk("rstmid_busy", busy18, 32'h0);
    chk("rstmid_no_rsp", rsp_valid18, 32'h0);
    tick();
    p_reset18 = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rstmid_not_accepted_psel", psel18, 32'h0);
    chk("rstmid_not_accepted_busy", busy18, 32'h0);
    chk("rstmid_no_rsp2", rsp_valid18, 32'h0);
    drive(1'b1, 1'b0, 8'h40, 32'h0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    chk("post_rst_psel", psel18, 32'h2);
    tick();
    tick();
    chk("post_rst_rsp_valid", rsp_valid18, 32'h1);
    chk("post_rst_rdata", rsp_rdata18, 32'h1111_1111);

    // Idle hold after a write to 0x10
    drive(1'b1, 1'b1, 8'h10, 32'h0000_0001);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_paddr", paddr18, 32'h10);
      chk("idle_pwrite", pwrite18, 32'h1);
      chk("idle_psel", psel18, 32'h0);
      chk("idle_penable", penable18, 32'h0);
      chk("idle_busy", busy18, 32'h0);
    end

    // Accept during ENABLE with an empty FIFO: no idle bubble
    drive(1'b1, 1'b1, 8'h08, 32'h0000_0008);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    chk("bub_psel1", psel18, 32'h1);
    chk("bub_pen1", penable18, 32'h0);
    tick();
    chk("bub_psel2", psel18, 32'h1);
    chk("bub_pen2", penable18, 32'h1);
    drive(1'b1, 1'b1, 8'h0C, 32'h0000_000C);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    chk("bub_psel3", psel18, 32'h1);
    chk("bub_pen3", penable18, 32'h0);
    chk("bub_paddr3", paddr18, 32'h0C);
    chk("bub_pwdata3", pwdata18, 32'h0000_000C);
    chk("bub_rsp_first", rsp_valid18, 32'h1);
    tick();
    chk("bub_psel4", psel18, 32'h1);
    chk("bub_pen4", penable18, 32'h1);
    tick();
    chk("bub_psel5", psel18, 32'h0);
    chk("bub_rsp_second", rsp_valid18, 32'h1);
    chk("bub_busy_end", busy18, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
